// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the 5-stage RV32IM pipeline.
// Resolves load-use hazards and taken-branch flushes, and holds the front end
// while a multi-cycle MUL/DIV/REM op occupies EX.
// Optional build macro: HAZARD_STALL_COUNTER_EN adds a free-running 32-bit
// count of PC stall cycles on port STALL_CYCLES.
module pipeline_hazard_ctrl #(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 33
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  ID_RS1_ADDR,
  input  logic [4:0]  ID_RS2_ADDR,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic [4:0]  EX_WRITE_ADDR,
  input  logic        EX_WRITE_ENABLE,
  input  logic        EX_DATA_MEM_SELECT,
  input  logic        EX_MDU_VALID,
  input  logic        EX_MDU_IS_DIV,
  input  logic        EX_BRANCH_TAKEN,
  output logic        PC_STALL,
  output logic        IF_ID_STALL,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_STALL,
  output logic        ID_EX_FLUSH,
  output logic        EX_MEM_FLUSH,
  output logic        MDU_START,
  output logic        MDU_BUSY
`ifdef HAZARD_STALL_COUNTER_EN
  ,
  output logic [31:0] STALL_CYCLES
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_MDU_DONE = 2'd2
  } state_t;

  // The start cycle itself is the first of LATENCY stall cycles, so the
  // counter is loaded with LATENCY-1 and MDU_WAIT covers the rest.
  localparam logic [5:0] LP_MUL_CNT = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] LP_DIV_CNT = 6'(DIV_LATENCY - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_cnt;
  logic [5:0] w_cnt_nxt;
  logic       w_rs1_hit;
  logic       w_rs2_hit;
  logic       w_load_use;

  // Load-use detection: a load in EX whose (non-x0) destination feeds ID.
  always_comb begin
    w_rs1_hit  = ID_USES_RS1 && (ID_RS1_ADDR == EX_WRITE_ADDR);
    w_rs2_hit  = ID_USES_RS2 && (ID_RS2_ADDR == EX_WRITE_ADDR);
    w_load_use = EX_DATA_MEM_SELECT && EX_WRITE_ENABLE &&
                 (EX_WRITE_ADDR != 5'd0) && (w_rs1_hit || w_rs2_hit);
  end

  // Next-state, counter and pipeline-control decode from state and inputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    PC_STALL     = 1'b0;
    IF_ID_STALL  = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_STALL  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    EX_MEM_FLUSH = 1'b0;
    MDU_START    = 1'b0;
    MDU_BUSY     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (EX_MDU_VALID) begin
          // MDU wins over a (illegal) simultaneous branch: no flush issued.
          MDU_START    = 1'b1;
          PC_STALL     = 1'b1;
          IF_ID_STALL  = 1'b1;
          ID_EX_STALL  = 1'b1;
          EX_MEM_FLUSH = 1'b1;
          w_cnt_nxt    = EX_MDU_IS_DIV ? LP_DIV_CNT : LP_MUL_CNT;
          w_state_nxt  = ST_MDU_WAIT;
        end else if (EX_BRANCH_TAKEN) begin
          IF_ID_FLUSH = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end else if (w_load_use) begin
          // One bubble is enough: the load moves to MEM next cycle.
          PC_STALL    = 1'b1;
          IF_ID_STALL = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end
      end
      ST_MDU_WAIT: begin
        // Branch and load-use inputs are meaningless while EX is occupied.
        MDU_BUSY     = 1'b1;
        PC_STALL     = 1'b1;
        IF_ID_STALL  = 1'b1;
        ID_EX_STALL  = 1'b1;
        EX_MEM_FLUSH = 1'b1;
        if (r_cnt == 6'd1) begin
          w_cnt_nxt   = 6'd0;
          w_state_nxt = ST_MDU_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 6'd1;
        end
      end
      ST_MDU_DONE: begin
        // EX_MEM captures the result now. EX_MDU_VALID is still high for the
        // finishing op and must not restart the unit; branches are ignored.
        if (w_load_use) begin
          PC_STALL    = 1'b1;
          IF_ID_STALL = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 6'd0;
      end
    endcase
  end

  // State and latency counter; reset aborts any MDU op in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_RUN;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZARD_STALL_COUNTER_EN
  logic [31:0] r_stall_cycles;

  // Performance counter of front-end stall cycles, wrapping at 2^32.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cycles <= 32'd0;
    end else if (PC_STALL) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign STALL_CYCLES = r_stall_cycles;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MUL_LATENCY=3, DIV_LATENCY=33).
// Output vector order: {PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL,
//                       ID_EX_FLUSH, EX_MEM_FLUSH, MDU_START, MDU_BUSY}
module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] O_NONE   = 8'h00;
  localparam logic [7:0] O_LDUSE  = 8'hC8;
  localparam logic [7:0] O_BRANCH = 8'h28;
  localparam logic [7:0] O_START  = 8'hD6;
  localparam logic [7:0] O_WAIT   = 8'hD5;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] ID_RS1_ADDR, ID_RS2_ADDR, EX_WRITE_ADDR;
  logic       ID_USES_RS1, ID_USES_RS2, EX_WRITE_ENABLE, EX_DATA_MEM_SELECT;
  logic       EX_MDU_VALID, EX_MDU_IS_DIV, EX_BRANCH_TAKEN;
  logic       PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL;
  logic       ID_EX_FLUSH, EX_MEM_FLUSH, MDU_START, MDU_BUSY;
`ifdef HAZARD_STALL_COUNTER_EN
  logic [31:0] STALL_CYCLES;
`endif
  logic [7:0] w_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.MUL_LATENCY(3), .DIV_LATENCY(33)) dut (
    .CLK(CLK), .RST(RST),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .EX_WRITE_ADDR(EX_WRITE_ADDR), .EX_WRITE_ENABLE(EX_WRITE_ENABLE),
    .EX_DATA_MEM_SELECT(EX_DATA_MEM_SELECT), .EX_MDU_VALID(EX_MDU_VALID),
    .EX_MDU_IS_DIV(EX_MDU_IS_DIV), .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
    .PC_STALL(PC_STALL), .IF_ID_STALL(IF_ID_STALL), .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_STALL(ID_EX_STALL), .ID_EX_FLUSH(ID_EX_FLUSH),
    .EX_MEM_FLUSH(EX_MEM_FLUSH), .MDU_START(MDU_START), .MDU_BUSY(MDU_BUSY)
`ifdef HAZARD_STALL_COUNTER_EN
    , .STALL_CYCLES(STALL_CYCLES)
`endif
  );

  assign w_out = {PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL,
                  ID_EX_FLUSH, EX_MEM_FLUSH, MDU_START, MDU_BUSY};

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] wa;
    logic       we;
    logic       ld;
    logic       mv;
    logic       md;
    logic       br;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic rst, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic [4:0] wa, logic we,
                              logic ld, logic mv, logic md, logic br,
                              logic [7:0] exp);
    vec_t v;
    v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.wa = wa; v.we = we; v.ld = ld; v.mv = mv; v.md = md; v.br = br;
    v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    RST = 1'b0;
    ID_RS1_ADDR = 5'd0; ID_RS2_ADDR = 5'd0; ID_USES_RS1 = 1'b0;
    ID_USES_RS2 = 1'b0; EX_WRITE_ADDR = 5'd0; EX_WRITE_ENABLE = 1'b0;
    EX_DATA_MEM_SELECT = 1'b0; EX_MDU_VALID = 1'b0; EX_MDU_IS_DIV = 1'b0;
    EX_BRANCH_TAKEN = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    RST = v.rst; ID_RS1_ADDR = v.rs1; ID_RS2_ADDR = v.rs2;
    ID_USES_RS1 = v.u1; ID_USES_RS2 = v.u2; EX_WRITE_ADDR = v.wa;
    EX_WRITE_ENABLE = v.we; EX_DATA_MEM_SELECT = v.ld;
    EX_MDU_VALID = v.mv; EX_MDU_IS_DIV = v.md; EX_BRANCH_TAKEN = v.br;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    clr_in();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    int   n_stall;
    int   n_start;
    int   n_busy;
    logic [7:0] exp;

    //            rst rs1 rs2 u1 u2 wa we ld mv md br exp
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
    vecs[1]  = mk(0, 5, 1, 1, 1, 5, 1, 1, 0, 0, 0, O_LDUSE);   // lw x5; add x6,x5,x1
    vecs[2]  = mk(0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0, O_NONE);    // rd = x0
    vecs[3]  = mk(0, 1, 9, 1, 1, 9, 1, 1, 0, 0, 0, O_LDUSE);   // rs2 match
    vecs[4]  = mk(0, 7, 2, 0, 1, 7, 1, 1, 0, 0, 0, O_NONE);    // rs1 match, unused
    vecs[5]  = mk(0, 5, 0, 1, 0, 5, 0, 1, 0, 0, 0, O_NONE);    // no write
    vecs[6]  = mk(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, O_NONE);    // ALU producer
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_BRANCH);
    vecs[8]  = mk(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 1, O_BRANCH);  // branch beats load-use
    vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, O_START);   // MDU beats branch
    vecs[10] = mk(1, 3, 0, 1, 0, 3, 1, 1, 1, 1, 0, O_START);   // MDU beats load-use
    vecs[11] = mk(0, 31, 31, 0, 1, 31, 1, 1, 0, 0, 0, O_LDUSE);

    clr_in();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1 chk("reset_state", {24'd0, w_out}, {24'd0, O_NONE});

    // Single-cycle RUN decode; each vector must leave the controller in RUN.
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      apply(vecs[i]);
      #1 chk($sformatf("vec%0d", i), {24'd0, w_out}, {24'd0, vecs[i].exp});
      @(negedge CLK);
      clr_in();
      #1 chk($sformatf("vec%0d_after", i), {24'd0, w_out}, {24'd0, O_NONE});
    end

    // MUL: start at 0, busy 1-2, done at 3 with VALID still high, RUN at 4.
    // Branch driven during wait/done must be ignored.
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      clr_in();
      EX_MDU_VALID    = (k <= 3);
      EX_BRANCH_TAKEN = (k >= 1 && k <= 3);
      exp = (k == 0) ? O_START : (k <= 2) ? O_WAIT : O_NONE;
      #1 chk($sformatf("mul_c%0d", k), {24'd0, w_out}, {24'd0, exp});
    end

    // Back-to-back DIV: 33 stall cycles, done at 33, second start at 34.
    do_reset();
    n_stall = 0; n_start = 0; n_busy = 0;
    for (int k = 0; k < 35; k++) begin
      if (k > 0) @(negedge CLK);
      clr_in();
      EX_MDU_VALID  = 1'b1;
      EX_MDU_IS_DIV = 1'b1;
      if (k >= 5 && k <= 7) begin
        EX_DATA_MEM_SELECT = 1'b1; EX_WRITE_ENABLE = 1'b1;
        EX_WRITE_ADDR = 5'd4; ID_RS1_ADDR = 5'd4; ID_USES_RS1 = 1'b1;
      end
      exp = (k == 0 || k == 34) ? O_START : (k <= 32) ? O_WAIT : O_NONE;
      #1 chk($sformatf("div_c%0d", k), {24'd0, w_out}, {24'd0, exp});
      if (k <= 33) begin
        n_stall += int'(PC_STALL);
        n_start += int'(MDU_START);
        n_busy  += int'(MDU_BUSY);
      end
    end
    chk("div_stall_cycles", n_stall, 33);
    chk("div_start_pulses", n_start, 1);
    chk("div_busy_cycles", n_busy, 32);

    // Reset while the second DIV is waiting: outputs still decode WAIT.
    @(negedge CLK);
    clr_in();
    RST = 1'b1;
    #1 chk("div2_rst_cycle", {24'd0, w_out}, {24'd0, O_WAIT});
    @(negedge CLK);
    RST = 1'b0;
    #1 chk("div2_after_rst", {24'd0, w_out}, {24'd0, O_NONE});

    // Reset at cycle 10 of a DIV aborts it.
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      clr_in();
      EX_MDU_VALID  = (k < 10);
      EX_MDU_IS_DIV = 1'b1;
      RST           = (k == 10);
      exp = (k == 0) ? O_START : (k <= 10) ? O_WAIT : O_NONE;
      #1 chk($sformatf("abort_c%0d", k), {24'd0, w_out}, {24'd0, exp});
    end

    // A fresh DIV after the abort runs the full count again.
    n_stall = 0; n_start = 0;
    for (int k = 0; k < 35; k++) begin
      @(negedge CLK);
      clr_in();
      EX_MDU_VALID  = (k <= 33);
      EX_MDU_IS_DIV = 1'b1;
      #1;
      n_stall += int'(PC_STALL);
      n_start += int'(MDU_START);
      if (k == 32 || k == 33 || k == 34) begin
        exp = (k == 32) ? O_WAIT : O_NONE;
        chk($sformatf("redo_c%0d", k), {24'd0, w_out}, {24'd0, exp});
      end
    end
    chk("redo_stall_cycles", n_stall, 33);
    chk("redo_start_pulses", n_start, 1);

    // Load-use in MDU_DONE is still decoded.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      clr_in();
      EX_MDU_VALID = (k <= 3);
      if (k == 3) begin
        EX_DATA_MEM_SELECT = 1'b1; EX_WRITE_ENABLE = 1'b1;
        EX_WRITE_ADDR = 5'd8; ID_RS2_ADDR = 5'd8; ID_USES_RS2 = 1'b1;
      end
    end
    #1 chk("done_loaduse", {24'd0, w_out}, {24'd0, O_LDUSE});

`ifdef HAZARD_STALL_COUNTER_EN
    // MUL (3 stall cycles) then one load-use stall -> 4.
    do_reset();
    #1 chk("cnt_after_rst0", STALL_CYCLES, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      clr_in();
      EX_MDU_VALID = (k <= 3);
      if (k == 4) begin
        EX_DATA_MEM_SELECT = 1'b1; EX_WRITE_ENABLE = 1'b1;
        EX_WRITE_ADDR = 5'd5; ID_RS1_ADDR = 5'd5; ID_USES_RS1 = 1'b1;
      end
    end
    #1 chk("cnt_mul_plus_lu", STALL_CYCLES, 32'd4);
    do_reset();
    #1 chk("cnt_after_rst1", STALL_CYCLES, 32'd0);
`endif

    @(negedge CLK);
    clr_in();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
